// File: rtl/mem_bank_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the memory bank.
// The master side is the environment (requesters and memory bank); the slave side is the arbiter.
interface mem_bank_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  hold;
  logic                  busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out, hold,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data_in,
           mem_write_enable, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out, hold,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data_in,
           mem_write_enable, busy
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory bank.
// Each access takes IDLE -> ACCESS -> DONE, all outputs come straight from flops.
module mem_bank_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  mem_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  mem_we_q, mem_we_d;
  // Port that won the most recent arbitration; 1 after reset so port 0 wins the first tie.
  logic                  last_q, last_d;
  logic                  win;

  // Next-state and registered-output logic for the three-phase access.
  always_comb begin
    state_d    = state_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    last_d     = last_q;
    win        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!bus.hold && (bus.req0 || bus.req1)) begin
          // On a tie the port not granted last time wins.
          win        = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          last_d     = win;
          gnt0_d     = ~win;
          gnt1_d     = win;
          mem_addr_d = win ? bus.addr1 : bus.addr0;
          mem_din_d  = win ? bus.wdata1 : bus.wdata0;
          mem_we_d   = win ? bus.we1 : bus.we0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        // The granted port is the one whose gnt flop is high this cycle.
        rvalid0_d = gnt0_q;
        rvalid1_d = gnt1_q;
        if (!mem_we_q) begin
          if (gnt0_q) rdata0_d = bus.mem_data_out;
          if (gnt1_q) rdata1_d = bus.mem_data_out;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      last_q     <= last_d;
    end
  end

  assign bus.gnt0             = gnt0_q;
  assign bus.gnt1             = gnt1_q;
  assign bus.rvalid0          = rvalid0_q;
  assign bus.rvalid1          = rvalid1_q;
  assign bus.rdata0           = rdata0_q;
  assign bus.rdata1           = rdata1_q;
  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_data_in      = mem_din_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.busy             = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: transaction-level predictor feeds a queue, a monitor checks it.
module tb_mem_bank_arbiter;

  typedef struct {
    int         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] data;  // write data, or expected read data
    int         gcyc;  // cycle in which gnt must be high
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_bank_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  mem_bank_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i * 29 + 7);
    if (i == 31) v = 8'hC7;
    return v;
  endfunction

  // Memory bank: combinational read, write on the rising edge.
  logic [7:0] bank [32];
  bit         mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_write_enable) begin
      bank[bus.mem_address] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out = bank[bus.mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbiter free/busy as a cycle number, round-robin as "last port".
  logic [7:0] ref_mem [32];
  exp_t       exp_q [$];
  exp_t       pe;
  int         next_free = 0;
  int         m_last = 1;
  logic [7:0] m_rd0 = 8'h00;
  logic [7:0] m_rd1 = 8'h00;

  initial for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      next_free = cyc + 1;
      m_last    = 1;
      m_rd0     = 8'h00;
      m_rd1     = 8'h00;
    end else if (cyc >= next_free && !bus.hold && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) pe.port = 1 - m_last;
      else                      pe.port = bus.req1 ? 1 : 0;
      pe.we   = (pe.port == 1) ? bus.we1 : bus.we0;
      pe.addr = (pe.port == 1) ? bus.addr1 : bus.addr0;
      pe.data = (pe.port == 1) ? bus.wdata1 : bus.wdata0;
      if (pe.we) begin
        ref_mem[pe.addr] = pe.data;
      end else begin
        pe.data = ref_mem[pe.addr];
        if (pe.port == 1) m_rd1 = pe.data;
        else              m_rd0 = pe.data;
      end
      pe.gcyc   = cyc + 1;
      m_last    = pe.port;
      next_free = cyc + 3;
      exp_q.push_back(pe);
    end
  end

  // Monitor: pop on gnt, check the completion one cycle later.
  exp_t inflight;
  bit   have_if = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      have_if = 1'b0;
    end else begin
      chk("gnt_both", 32'(bus.gnt0 & bus.gnt1), 0);
      chk("rvalid_both", 32'(bus.rvalid0 & bus.rvalid1), 0);
      chk("we_without_gnt", 32'(bus.mem_write_enable & ~(bus.gnt0 | bus.gnt1)), 0);
      if (exp_q.size() > 0 && exp_q[0].gcyc < cyc) begin
        me = exp_q.pop_front();
        chk("gnt_missing_at_cycle", cyc - 1, me.gcyc);
      end
      if (bus.gnt0 || bus.gnt1) begin
        if (exp_q.size() == 0 || exp_q[0].gcyc != cyc) begin
          chk("gnt_unexpected", {30'd0, bus.gnt1, bus.gnt0}, 0);
        end else begin
          me = exp_q.pop_front();
          chk("gnt_port", {30'd0, bus.gnt1, bus.gnt0}, (me.port == 1) ? 2 : 1);
          chk("mem_address", 32'(bus.mem_address), 32'(me.addr));
          chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(me.we));
          if (me.we) chk("mem_data_in", 32'(bus.mem_data_in), 32'(me.data));
          inflight = me;
          have_if  = 1'b1;
        end
      end else if (have_if && cyc == inflight.gcyc + 1) begin
        chk("rvalid_port", {30'd0, bus.rvalid1, bus.rvalid0}, (inflight.port == 1) ? 2 : 1);
        chk("rdata0", 32'(bus.rdata0), 32'(m_rd0));
        chk("rdata1", 32'(bus.rdata1), 32'(m_rd1));
        have_if = 1'b0;
      end else begin
        chk("rvalid_unexpected", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
      end
    end
  end

  // Advance one cycle; a requester releases its request once granted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.gnt0) bus.req0 = 1'b0;
    if (bus.gnt1) bus.req1 = 1'b0;
  endtask

  task automatic issue(input int port, input bit we, input logic [4:0] a, input logic [7:0] d);
    if (port == 1) begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end
  endtask

  task automatic wait_gnt(input int port);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if ((port == 0 && bus.gnt0) || (port == 1 && bus.gnt1)) ok = 1'b1;
    end
    chk("wait_gnt", 32'(ok), 1);
  endtask

  task automatic wait_any(output int port);
    bit ok;
    ok   = 1'b0;
    port = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) begin
        ok   = 1'b1;
        port = bus.gnt1 ? 1 : 0;
      end
    end
    chk("wait_any_gnt", 32'(ok), 1);
  endtask

  int p;

  initial begin
    rst = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.hold = 0;
    repeat (3) tick();
    chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_rdata", {16'd0, bus.rdata1, bus.rdata0}, 0);
    chk("rst_mem", {18'd0, bus.mem_write_enable, bus.mem_address, bus.mem_data_in}, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;

    // Both ports requesting continuously: grants alternate starting with port 0.
    issue(0, 0, 5'd1, 8'h00);
    issue(1, 0, 5'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      wait_any(p);
      chk("alternate_order", p, i % 2);
      issue(p, 0, 5'(i + 3), 8'h00);
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (3) tick();

    // Port 0 write 0xA5 to address 3, then read it back.
    issue(0, 1, 5'd3, 8'hA5);
    wait_gnt(0);
    chk("write_we", 32'(bus.mem_write_enable), 1);
    tick();
    chk("write_rvalid0", 32'(bus.rvalid0), 1);
    issue(0, 0, 5'd3, 8'h00);
    wait_gnt(0);
    tick();
    chk("read_rvalid0", 32'(bus.rvalid0), 1);
    chk("read_rdata0", 32'(bus.rdata0), 32'h0A5);
    tick();

    // Hold blocks new grants.
    bus.hold = 1'b1;
    issue(1, 0, 5'd7, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_idle", {29'd0, bus.busy, bus.mem_write_enable, bus.gnt1}, 0);
    end
    bus.hold = 1'b0;
    wait_gnt(1);
    repeat (2) tick();

    // Hold rising during an access does not stop it.
    issue(1, 0, 5'd31, 8'h00);
    wait_gnt(1);
    bus.hold = 1'b1;
    tick();
    chk("hold_late_rvalid1", 32'(bus.rvalid1), 1);
    chk("hold_late_rdata1", 32'(bus.rdata1), 32'h0C7);
    bus.hold = 1'b0;
    tick();

    // A port 1 write does not disturb rdata1; port 0 reads address 31.
    issue(1, 1, 5'd9, 8'h5E);
    wait_gnt(1);
    repeat (2) tick();
    issue(0, 0, 5'd31, 8'h00);
    wait_gnt(0);
    tick();
    chk("p0_rvalid0", 32'(bus.rvalid0), 1);
    chk("p0_rdata0", 32'(bus.rdata0), 32'h0C7);
    chk("p1_rdata1_kept", 32'(bus.rdata1), 32'h0C7);
    tick();

    // Reset during an access aborts it; the next tie goes to port 0.
    issue(1, 0, 5'd4, 8'h00);
    wait_gnt(1);
    repeat (2) tick();
    issue(0, 1, 5'd5, 8'h3C);
    wait_gnt(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", {27'd0, bus.busy, bus.mem_write_enable, bus.rvalid0, bus.rvalid1,
                          bus.gnt0 | bus.gnt1}, 0);
    chk("abort_rdata", {16'd0, bus.rdata1, bus.rdata0}, 0);
    chk("abort_mem_addr", 32'(bus.mem_address), 0);
    issue(0, 0, 5'd6, 8'h00);
    issue(1, 0, 5'd8, 8'h00);
    wait_any(p);
    chk("abort_tie_winner", p, 0);
    bus.req1 = 0;
    repeat (3) tick();

    // Randomised traffic with random hold.
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!bus.req0 && $urandom_range(0, 99) < 40)
        issue(0, 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
      if (!bus.req1 && $urandom_range(0, 99) < 40)
        issue(1, 1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
      bus.hold = ($urandom_range(0, 99) < 15);
    end
    bus.hold = 1'b0;
    repeat (12) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("inflight_done", 32'(have_if), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
